pic_ctrl_seq: RTL and testbench

Clocked, parametrised control sequencer for the programmable interrupt controller. It decodes the ICW1–ICW4 initialisation sequence and OCW1–OCW3 writes. It runs the two-pulse INTA acknowledge sequence, issues EOI/AEOI clears and priority rotation, and supports poll mode. It sits between the read/write logic and the IRR/ISR/priority-resolver/cascade blocks, replacing the event-triggered control logic with a single-clock synchronous design scalable to `N_IRQ` channels.

---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_ctrl_seq_if.sv | 12 +
 rtl/pic_rot_pick.sv | 28 ++
 rtl/pic_ctrl_seq.sv | 178 +++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and command encodings for the PIC control sequencer.
package pic_pkg;

  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} init_st_e;
  typedef enum logic [1:0] {A_IDLE, A_P1, A_P2} ack_st_e;

  // OCW2 command field d[7:5]
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // Read-register select from OCW3
  localparam logic RSEL_IRR = 1'b0;
  localparam logic RSEL_ISR = 1'b1;

  // Index of the lowest set bit of a one-hot (or zero) byte.
  function automatic logic [2:0] oh2id(input logic [7:0] v);
    oh2id = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) oh2id = 3'(i);
  endfunction

endpackage

// File: rtl/pic_ctrl_seq_if.sv
// CPU-side register bus: write and read strobes with registered read data.
interface pic_ctrl_seq_if;
  logic       wr_stb;
  logic       wr_a0;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic       rd_a0;
  logic [7:0] rd_data;

  modport master (output wr_stb, wr_a0, wr_data, rd_stb, rd_a0, input rd_data);
  modport slave  (input wr_stb, wr_a0, wr_data, rd_stb, rd_a0, output rd_data);
endinterface

// File: rtl/pic_rot_pick.sv
// Rotating first-set picker: scans from base+1 upward (mod N_IRQ).
module pic_rot_pick #(
  parameter int N_IRQ = 8,
  parameter int IDW   = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] vec,
  input  logic [IDW-1:0]   base,
  output logic [N_IRQ-1:0] onehot,
  output logic [IDW-1:0]   id,
  output logic             valid
);
  // First set bit after base wins; base itself is the lowest priority.
  always_comb begin : pick
    int idx;
    idx    = 0;
    onehot = '0;
    id     = '0;
    valid  = 1'b0;
    for (int i = 1; i <= N_IRQ; i++) begin
      idx = (int'(base) + i) % N_IRQ;
      if (!valid && vec[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
        id          = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/pic_ctrl_seq.sv
// PIC control sequencer: ICW/OCW decode, INTA sequence, EOI/rotation, poll.
module pic_ctrl_seq
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int IDW   = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  pic_ctrl_seq_if.slave    bus,
  input  logic             inta_n,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] isr,
  output logic             int_o,
  output logic [N_IRQ-1:0] imr,
  output logic             smm,
  output logic             level_mode,
  output logic [N_IRQ-1:0] isr_set,
  output logic [N_IRQ-1:0] irr_clr,
  output logic [N_IRQ-1:0] eoi_clr,
  output logic [IDW-1:0]   rotate_base,
  output logic             freeze,
  output logic [7:0]       vec_data,
  output logic             vec_oe,
  output logic [7:0]       icw2_q,
  output logic [7:0]       icw3_q,
  output logic             sngl,
  output logic             aeoi
);
  init_st_e         init_q, init_d;
  ack_st_e          ack_q, ack_d;
  logic [N_IRQ-1:0] imr_q, imr_d, isr_set_q, isr_set_d, irr_clr_q, irr_clr_d;
  logic [N_IRQ-1:0] eoi_clr_q, eoi_clr_d, ack_bit_q, ack_bit_d;
  logic [IDW-1:0]   rot_q, rot_d;
  logic [7:0]       icw2_d, icw3_d, vec_data_q, vec_data_d, rd_q, rd_d;
  logic [2:0]       ack_id_q, ack_id_d, req_id;
  logic smm_q, smm_d, level_q, level_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic aeoi_q, aeoi_d, arot_q, arot_d, freeze_q, freeze_d, vec_oe_q, vec_oe_d;
  logic int_q, int_d, poll_q, poll_d, rsel_q, rsel_d, inta_q;
  logic inta_fall, inta_rise, icw1;
  logic [7:0]       d;
  logic [N_IRQ-1:0] pick_oh, l_oh;
  logic [IDW-1:0]   pick_id, l_id;
  logic             pick_vld;

  pic_rot_pick #(.N_IRQ(N_IRQ), .IDW(IDW)) u_pick (
    .vec(isr), .base(rot_q), .onehot(pick_oh), .id(pick_id), .valid(pick_vld)
  );

  assign d         = bus.wr_data;
  assign l_id      = d[IDW-1:0];
  assign l_oh      = N_IRQ'(1) << l_id;
  assign icw1      = bus.wr_stb & ~bus.wr_a0 & d[4];
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  // A spurious acknowledge/poll reports the lowest-priority fixed id.
  assign req_id    = (|irq_req) ? oh2id(8'(irq_req)) : 3'(N_IRQ-1);

  // Next state: ack sequence, then reads, then writes (ICW1 overrides all).
  always_comb begin
    init_d = init_q;   ack_d = ack_q;       imr_d = imr_q;     rot_d = rot_q;
    smm_d = smm_q;     level_d = level_q;   sngl_d = sngl_q;   ic4_d = ic4_q;
    aeoi_d = aeoi_q;   arot_d = arot_q;     freeze_d = freeze_q;
    vec_oe_d = vec_oe_q; vec_data_d = vec_data_q; rd_d = rd_q;
    icw2_d = icw2_q;   icw3_d = icw3_q;     poll_d = poll_q;   rsel_d = rsel_q;
    ack_bit_d = ack_bit_q; ack_id_d = ack_id_q;
    isr_set_d = '0;    irr_clr_d = '0;      eoi_clr_d = '0;

    unique case (ack_q)
      A_IDLE: if (inta_fall) begin
        ack_bit_d = irq_req; ack_id_d = req_id; freeze_d = 1'b1; ack_d = A_P1;
      end
      A_P1: if (inta_rise) begin
        isr_set_d = ack_bit_q; irr_clr_d = ack_bit_q;
      end else if (inta_fall) begin
        vec_oe_d = 1'b1; vec_data_d = {icw2_q[7:3], ack_id_q}; ack_d = A_P2;
      end
      A_P2: if (inta_rise) begin
        vec_oe_d = 1'b0; freeze_d = 1'b0; ack_d = A_IDLE;
        if (aeoi_q) begin
          eoi_clr_d = ack_bit_q;
          if (arot_q) rot_d = IDW'(ack_id_q);
        end
      end
      default: ack_d = A_IDLE;
    endcase

    if (bus.rd_stb) begin
      if (bus.rd_a0) rd_d = 8'(imr_q);
      else if (poll_q) begin
        rd_d      = {|irq_req, 4'b0, req_id};
        isr_set_d = isr_set_d | irq_req;
        irr_clr_d = irr_clr_d | irq_req;
        poll_d    = 1'b0;
      end else rd_d = (rsel_q == RSEL_ISR) ? 8'(isr) : 8'(irr);
    end

    if (icw1) begin
      init_d = W_ICW2; imr_d = '0; isr_set_d = '0; irr_clr_d = '0; eoi_clr_d = '0;
      smm_d = 1'b0; aeoi_d = 1'b0; arot_d = 1'b0; rot_d = IDW'(N_IRQ-1);
      level_d = d[3]; sngl_d = d[1]; ic4_d = d[0];
      ack_d = A_IDLE; freeze_d = 1'b0; vec_oe_d = 1'b0;
    end else if (bus.wr_stb) begin
      unique case (init_q)
        W_ICW2: if (bus.wr_a0) begin
          icw2_d = d;
          init_d = !sngl_q ? W_ICW3 : (ic4_q ? W_ICW4 : READY);
        end
        W_ICW3: if (bus.wr_a0) begin
          icw3_d = d; init_d = ic4_q ? W_ICW4 : READY;
        end
        W_ICW4: if (bus.wr_a0) begin
          aeoi_d = d[1]; init_d = READY;
        end
        READY: if (bus.wr_a0) imr_d = d[N_IRQ-1:0];
        else if (d[4:3] == 2'b00) begin
          // OCW2 rotation is applied after AEOI so it wins a conflict.
          unique case (d[7:5])
            OCW2_NS_EOI:       eoi_clr_d = eoi_clr_d | pick_oh;
            OCW2_SP_EOI:       eoi_clr_d = eoi_clr_d | l_oh;
            OCW2_ROT_NS_EOI:   if (pick_vld) begin
                                 eoi_clr_d = eoi_clr_d | pick_oh; rot_d = pick_id;
                               end
            OCW2_ROT_SP_EOI:   begin eoi_clr_d = eoi_clr_d | l_oh; rot_d = l_id; end
            OCW2_SET_PRIO:     rot_d = l_id;
            OCW2_ROT_AEOI_SET: arot_d = 1'b1;
            OCW2_ROT_AEOI_CLR: arot_d = 1'b0;
            default: ;
          endcase
        end else if (d[4:3] == 2'b01) begin
          if (d[6]) smm_d = d[5];
          if (d[2]) poll_d = 1'b1;
          if (d[1]) rsel_d = d[0] ? RSEL_ISR : RSEL_IRR;
        end
        default: ;
      endcase
    end

    int_d = (|irq_req) & (init_d == READY) & (ack_d == A_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= UNINIT;   ack_q <= A_IDLE;    imr_q <= '0;      rot_q <= IDW'(N_IRQ-1);
      smm_q <= 1'b0;      level_q <= 1'b0;    sngl_q <= 1'b0;   ic4_q <= 1'b0;
      aeoi_q <= 1'b0;     arot_q <= 1'b0;     freeze_q <= 1'b0; vec_oe_q <= 1'b0;
      vec_data_q <= '0;   rd_q <= '0;         icw2_q <= '0;     icw3_q <= '0;
      poll_q <= 1'b0;     rsel_q <= RSEL_IRR; ack_bit_q <= '0;  ack_id_q <= '0;
      isr_set_q <= '0;    irr_clr_q <= '0;    eoi_clr_q <= '0;  int_q <= 1'b0;
      inta_q <= 1'b1;
    end else begin
      init_q <= init_d;   ack_q <= ack_d;     imr_q <= imr_d;   rot_q <= rot_d;
      smm_q <= smm_d;     level_q <= level_d; sngl_q <= sngl_d; ic4_q <= ic4_d;
      aeoi_q <= aeoi_d;   arot_q <= arot_d;   freeze_q <= freeze_d; vec_oe_q <= vec_oe_d;
      vec_data_q <= vec_data_d; rd_q <= rd_d; icw2_q <= icw2_d; icw3_q <= icw3_d;
      poll_q <= poll_d;   rsel_q <= rsel_d;   ack_bit_q <= ack_bit_d; ack_id_q <= ack_id_d;
      isr_set_q <= isr_set_d; irr_clr_q <= irr_clr_d; eoi_clr_q <= eoi_clr_d; int_q <= int_d;
      inta_q <= inta_n;
    end
  end

  assign bus.rd_data  = rd_q;
  assign int_o        = int_q;
  assign imr          = imr_q;
  assign smm          = smm_q;
  assign level_mode   = level_q;
  assign isr_set      = isr_set_q;
  assign irr_clr      = irr_clr_q;
  assign eoi_clr      = eoi_clr_q;
  assign rotate_base  = rot_q;
  assign freeze       = freeze_q;
  assign vec_data     = vec_data_q;
  assign vec_oe       = vec_oe_q;
  assign sngl         = sngl_q;
  assign aeoi         = aeoi_q;
endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Directed bench for pic_ctrl_seq with hand-computed expectations.
module tb_pic_ctrl_seq;
  import pic_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, inta_n = 1'b1;
  logic [7:0] irq_req = '0, irr = '0, isr = '0;
  logic       int_o, smm, level_mode, freeze, vec_oe, sngl, aeoi;
  logic [7:0] imr, isr_set, irr_clr, eoi_clr, vec_data, icw2_q, icw3_q;
  logic [2:0] rotate_base;
  int n_tests = 0, n_fail = 0;

  pic_ctrl_seq_if bus();

  pic_ctrl_seq #(.N_IRQ(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inta_n(inta_n),
    .irq_req(irq_req), .irr(irr), .isr(isr), .int_o(int_o), .imr(imr), .smm(smm),
    .level_mode(level_mode), .isr_set(isr_set), .irr_clr(irr_clr), .eoi_clr(eoi_clr),
    .rotate_base(rotate_base), .freeze(freeze), .vec_data(vec_data), .vec_oe(vec_oe),
    .icw2_q(icw2_q), .icw3_q(icw3_q), .sngl(sngl), .aeoi(aeoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] dat);
    bus.wr_a0 = a0; bus.wr_data = dat; bus.wr_stb = 1'b1;
    tick();
    bus.wr_stb = 1'b0;
  endtask

  task automatic rd(input logic a0);
    bus.rd_a0 = a0; bus.rd_stb = 1'b1;
    tick();
    bus.rd_stb = 1'b0;
  endtask

  task automatic inta(input logic v);
    inta_n = v;
    tick();
  endtask

  initial begin
    bus.wr_stb = 1'b0; bus.wr_a0 = 1'b0; bus.wr_data = '0;
    bus.rd_stb = 1'b0; bus.rd_a0 = 1'b0;
    tick(); tick();
    chk("rst_imr", 32'(imr), 0);
    chk("rst_rot", 32'(rotate_base), 7);
    chk("rst_int", 32'(int_o), 0);
    chk("rst_rd", 32'(bus.rd_data), 0);
    chk("rst_frz", 32'(freeze), 0);
    chk("rst_vec", 32'(vec_data), 0);
    rst_n = 1'b1;
    tick();

    // Writes before ICW1 are ignored; no interrupt until READY.
    irq_req = 8'h01;
    wr(1'b1, 8'hFF);
    chk("uninit_imr", 32'(imr), 0);
    chk("uninit_int", 32'(int_o), 0);
    irq_req = 8'h00;

    // Single mode with ICW4: ICW3 is skipped, AEOI on.
    wr(1'b0, 8'h13);
    chk("icw1_st", 32'(dut.init_q), 32'(W_ICW2));
    wr(1'b1, 8'h40);
    chk("icw2_st", 32'(dut.init_q), 32'(W_ICW4));
    wr(1'b1, 8'h03);
    chk("ready_st", 32'(dut.init_q), 32'(READY));
    chk("aeoi", 32'(aeoi), 1);
    chk("sngl", 32'(sngl), 1);
    chk("ltim", 32'(level_mode), 0);
    chk("icw2", 32'(icw2_q), 'h40);
    chk("imr0", 32'(imr), 0);
    chk("rot7", 32'(rotate_base), 7);

    // Full acknowledge of channel 3 with AEOI.
    irq_req = 8'h08;
    tick();
    chk("int_on", 32'(int_o), 1);
    inta(1'b0);
    chk("p1_frz", 32'(freeze), 1);
    chk("p1_int", 32'(int_o), 0);
    inta(1'b1);
    chk("p1_isrset", 32'(isr_set), 'h08);
    chk("p1_irrclr", 32'(irr_clr), 'h08);
    inta(1'b0);
    chk("p2_oe", 32'(vec_oe), 1);
    chk("p2_vec", 32'(vec_data), 'h43);
    inta(1'b1);
    chk("p2_eoi", 32'(eoi_clr), 'h08);
    chk("p2_oe_off", 32'(vec_oe), 0);
    chk("p2_frz_off", 32'(freeze), 0);
    chk("p2_rot", 32'(rotate_base), 7);
    irq_req = 8'h00;
    tick();
    chk("eoi_1cyc", 32'(eoi_clr), 0);

    // OCW2 rotation and EOI variants.
    wr(1'b0, 8'hC3);
    chk("setprio3", 32'(rotate_base), 3);
    isr = 8'h21;
    wr(1'b0, 8'hA0);
    chk("rns_eoi", 32'(eoi_clr), 'h20);
    chk("rns_rot", 32'(rotate_base), 5);
    wr(1'b0, 8'h62);
    chk("sp_eoi", 32'(eoi_clr), 'h04);
    wr(1'b0, 8'hC6);
    chk("setprio6", 32'(rotate_base), 6);
    chk("setprio_eoi", 32'(eoi_clr), 0);
    isr = 8'h00;
    wr(1'b0, 8'hA0);
    chk("ns_empty_eoi", 32'(eoi_clr), 0);
    chk("ns_empty_rot", 32'(rotate_base), 6);
    isr = 8'h81;
    wr(1'b0, 8'h20);
    chk("ns_wrap7", 32'(eoi_clr), 'h80);
    isr = 8'h41;
    wr(1'b0, 8'hA0);
    chk("rns_wrap0", 32'(eoi_clr), 'h01);
    chk("rns_rot0", 32'(rotate_base), 0);

    // OCW1 and register reads.
    wr(1'b1, 8'hA5);
    chk("ocw1", 32'(imr), 'hA5);
    rd(1'b1);
    chk("rd_imr", 32'(bus.rd_data), 'hA5);
    irr = 8'h3C;
    rd(1'b0);
    chk("rd_irr", 32'(bus.rd_data), 'h3C);
    wr(1'b0, 8'h0B);
    isr = 8'h12;
    rd(1'b0);
    chk("rd_isr", 32'(bus.rd_data), 'h12);
    wr(1'b0, 8'h68);
    chk("smm_set", 32'(smm), 1);
    wr(1'b0, 8'h48);
    chk("smm_clr", 32'(smm), 0);

    // Poll.
    wr(1'b0, 8'h0C);
    irq_req = 8'h10;
    rd(1'b0);
    chk("poll_rd", 32'(bus.rd_data), 'h84);
    chk("poll_isrset", 32'(isr_set), 'h10);
    chk("poll_irrclr", 32'(irr_clr), 'h10);
    rd(1'b0);
    chk("poll_done", 32'(bus.rd_data), 'h12);
    chk("poll_noset", 32'(isr_set), 0);

    // Auto-rotate on AEOI: channel 2 becomes lowest priority.
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h80);
    irq_req = 8'h04;
    inta(1'b0); inta(1'b1); inta(1'b0);
    chk("arot_vec", 32'(vec_data), 'h42);
    inta(1'b1);
    chk("arot_eoi", 32'(eoi_clr), 'h04);
    chk("arot_rot", 32'(rotate_base), 2);

    // Spurious acknowledge.
    irq_req = 8'h00;
    inta(1'b0); inta(1'b1);
    chk("spur_isrset", 32'(isr_set), 0);
    inta(1'b0);
    chk("spur_vec", 32'(vec_data), 'h47);
    inta(1'b1);
    chk("spur_eoi", 32'(eoi_clr), 0);

    // ICW1 aborts an acknowledge in progress.
    irq_req = 8'h02;
    tick();
    inta(1'b0);
    chk("abort_pre_frz", 32'(freeze), 1);
    wr(1'b0, 8'h1B);
    chk("abort_frz", 32'(freeze), 0);
    chk("abort_oe", 32'(vec_oe), 0);
    chk("abort_int", 32'(int_o), 0);
    chk("abort_st", 32'(dut.init_q), 32'(W_ICW2));
    chk("abort_rot", 32'(rotate_base), 7);
    chk("abort_ltim", 32'(level_mode), 1);
    inta(1'b1);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h01);
    chk("reinit_aeoi", 32'(aeoi), 0);
    tick();
    chk("reinit_int", 32'(int_o), 1);

    // Asynchronous reset in the middle of the second pulse.
    inta(1'b0); inta(1'b1); inta(1'b0);
    chk("pre_rst_oe", 32'(vec_oe), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(vec_oe), 0);
    chk("arst_frz", 32'(freeze), 0);
    chk("arst_vec", 32'(vec_data), 0);
    chk("arst_int", 32'(int_o), 0);
    inta_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
